autocorr_tempo_mc: RTL
======================

# autocorr_tempo_mc

Multi-channel autocorrelation tempo estimator for the onset-flux path of the mic spectrum / SNR pipeline. It stores NCH parallel flux streams in per-channel circular histories. On each start request it sweeps integer lags LAG_MIN..LAG_MAX on every channel in turn, and picks the lag with the highest pair-normalised score. It converts that lag to BPM with a sequential rounded divider and emits one result per channel.

## Interface
Parameters:
- NCH, 2: number of flux channels
- N, 512: history depth per channel (power of two)
- W, 24: flux sample width per channel
- CORR_W, 16: LSBs of each sample used in the MAC
- LAG_MIN, 3: first lag swept, in frames (≥1)
- LAG_MAX, 18: last lag swept, in frames (LAG_MAX+GUARD < N)
- GUARD, 64: history slots reserved for writes during a sweep
- FPS_Q8, 3000: frame rate in Q8 (12000/1024 Hz)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flux_valid  in  1  one frame of flux for all channels
- flux_in  in  NCH*W  channel c occupies bits [c*W +: W]
- start  in  1  sweep request pulse
- busy  out  1  sweep in progress
- result_valid  out  1  one-cycle pulse per channel result
- result_ch  out  max(1,$clog2(NCH))  channel of current result
- best_lag  out  $clog2(LAG_MAX+1)  winning lag, in frames
- bpm  out  16  rounded BPM
- best_score  out  ACCW  raw accumulator of the winning lag; ACCW = 2*CORR_W+$clog2(N)

## Operation
- History:
  - On flux_valid, all channels are written at shared wr_ptr. wr_ptr then increments mod N.
  - fill saturates at N.
  - Writes continue while busy.
- Start latch:
  - start sets pending only if fill > LAG_MAX; otherwise start is ignored.
  - start while busy sets pending, which is served after the current sweep. Only one request is held.
- States:
  - IDLE: on pending, capture base = wr_ptr−1 and usable = min(fill, N−GUARD). Clear pending. Set ch=0. Go to CH_INIT.
  - CH_INIT: set lag=LAG_MIN and best_valid=0. Go to LAG_INIT.
  - LAG_INIT: pairs = usable−lag (always ≥1). Clear acc and j.
  - ACC: each cycle, read age j and age j+lag (address = base−age mod N), then j++. Exit after pairs reads.
  - DRAIN: 2 cycles. The RAM has 1-cycle read latency, and the product is registered; acc += a[CORR_W-1:0]*b[CORR_W-1:0].
  - CMP:
    - Replace the best if !best_valid, or if acc*best_pairs > best_acc*pairs. The compare is unsigned at ACCW+$clog2(N) bits, so no division is needed.
    - Strict greater means ties keep the shorter lag.
    - If lag<LAG_MAX: lag++, go to LAG_INIT. Else go to DIV.
  - DIV: restoring divider, 32 cycles.
    - Numerator: 60*FPS_Q8 + best_lag*128.
    - Denominator: best_lag*256.
    - Quotient saturates at 16'hFFFF.
  - OUT:
    - Drive result_valid=1 with result_ch, best_lag, bpm and best_score.
    - If ch<NCH−1: ch++, go to CH_INIT. Else go to IDLE.
- busy = (state != IDLE).
- All-zero flux leaves LAG_MIN as the winner, because the first lag is always accepted.

## Timing
- Per lag: pairs+4 cycles (LAG_INIT 1, ACC pairs, DRAIN 2, CMP 1).
- Per channel: 1 + Σ(pairs+4) + 32 + 1 cycles.
- Start → busy: start registered at edge k sets pending; busy is 1 from k+2.
- result_valid lasts exactly 1 cycle. Output data holds until the next OUT.
- Reset (synchronous, any state including mid-sweep):
  - state IDLE; wr_ptr, fill and pending cleared.
  - All outputs 0, busy 0.
  - The RAM contents are not cleared; fill=0 masks them.
- Throughput constraint: a sweep must finish within GUARD frames. The integrator guarantees this; the block does not check it.

## Configuration
- AUTOCORR_TEMPO_MEDIAN3_EN defined:
  - bpm is the median of the last three raw per-channel results.
  - Histories are seeded to the first raw value after reset.
  - OUT latency is unchanged.
- Undefined: bpm is the raw divider result.

## Test plan
- Ch0 impulse train period 8 (value 100, else 0), 400 frames, start → ch0 best_lag=8, bpm=88.
- Ch0 period 6, ch1 period 12 → two result_valid pulses in order ch0/ch1: lag 6/bpm 117, then lag 12/bpm 59.
- All-zero flux, start → best_lag=3, bpm=234, best_score=0 on every channel.
- Start with fill=LAG_MAX (18 frames) → no busy, no result. After a 19th frame, start → results produced.
- Start pulsed twice during busy → exactly one extra full sweep. Reset asserted mid-ACC → next cycle busy=0, all outputs 0, and a subsequent start before 19 frames is ignored.
- With the macro defined, raw sequence 120, 60, 121 on ch0 → third bpm=120. Without the macro → 121.

Source files
------------

// File: rtl/autocorr_tempo_mc.sv
// ---------------------------------------------------------------------------
// autocorr_tempo_mc
//
// Multi-channel autocorrelation tempo estimator. NCH flux streams are kept in
// a shared circular history (one RAM word holds one frame of every channel).
// A start request sweeps lags LAG_MIN..LAG_MAX on each channel in turn. The
// lag with the highest pair-normalised score wins, and a restoring divider
// turns it into a rounded BPM value. One result is emitted per channel.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   flux_valid    one frame of flux for all channels is present on flux_in
//   flux_in       channel c at bits [c*W +: W]
//   start         sweep request pulse (ignored until fill > LAG_MAX)
//   busy          sweep in progress
//   result_valid  one-cycle pulse per channel result
//   result_ch     channel of the current result
//   best_lag      winning lag in frames
//   bpm           rounded BPM (median of last three when enabled)
//   best_score    raw accumulator of the winning lag
//
// Optional feature: define AUTOCORR_TEMPO_MEDIAN3_EN to report the median of
// the last three raw per-channel BPM values instead of the raw value.
// ---------------------------------------------------------------------------
module autocorr_tempo_mc #(
  parameter int NCH     = 2,
  parameter int N       = 512,
  parameter int W       = 24,
  parameter int CORR_W  = 16,
  parameter int LAG_MIN = 3,
  parameter int LAG_MAX = 18,
  parameter int GUARD   = 64,
  parameter int FPS_Q8  = 3000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flux_valid,
  input  logic [NCH*W-1:0]                      flux_in,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  result_valid,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] result_ch,
  output logic [$clog2(LAG_MAX+1)-1:0]          best_lag,
  output logic [15:0]                           bpm,
  output logic [2*CORR_W+$clog2(N)-1:0]         best_score
);

  localparam int AW   = $clog2(N);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LW   = $clog2(LAG_MAX + 1);
  localparam int ACCW = 2 * CORR_W + AW;
  localparam int CMPW = ACCW + AW;
  localparam int FW   = AW + 1;
  localparam logic [FW-1:0] USABLE_MAX = FW'(N - GUARD);
  localparam logic [31:0]   NUM_BASE   = 32'(60 * FPS_Q8);

  typedef enum logic [2:0] {
    S_IDLE, S_CH_INIT, S_LAG_INIT, S_ACC, S_DRAIN, S_CMP, S_DIV, S_OUT
  } state_t;

  state_t              state;
  logic [AW-1:0]       wr_ptr, base;
  logic [FW-1:0]       fill, usable, pairs, j, best_pairs;
  logic                pending, best_valid, drain_cnt;
  logic [CHW-1:0]      ch;
  logic [LW-1:0]       lag, win_lag;
  logic [ACCW-1:0]     acc, best_acc;
  logic [4:0]          div_cnt;
  logic [31:0]         num_q, den, rem;
  logic [NCH*W-1:0]    mem [N];
  logic [NCH*W-1:0]    rd_a, rd_b;
  logic                rd_v, prod_v;
  logic [2*CORR_W-1:0] prod;

  logic [AW-1:0]       addr_a, addr_b;
  logic                start_ok, replace, div_done, div_ge;
  logic [LW-1:0]       cmp_lag;
  logic [32:0]         rem_sh;
  logic [31:0]         rem_nxt, quo_nxt;
  logic [15:0]         raw_bpm, out_bpm;

  assign busy     = (state != S_IDLE);
  assign start_ok = start && (fill > FW'(LAG_MAX));
  assign addr_a   = base - j[AW-1:0];
  assign addr_b   = base - (j[AW-1:0] + AW'(lag));
  assign div_done = (state == S_DIV) && (div_cnt == 5'd31);

  // NOTE: the history RAM has no reset; fill masks stale contents and the
  // array stays mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (flux_valid) mem[wr_ptr] <= flux_in;
    rd_a <= mem[addr_a];
    rd_b <= mem[addr_b];
  end

  // Cross-multiplied score compare and one restoring-divider step.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    replace = !best_valid ||
              ((CMPW'(acc) * CMPW'(best_pairs)) > (CMPW'(best_acc) * CMPW'(pairs)));
    cmp_lag = replace ? lag : win_lag;
    rem_sh  = {rem, num_q[31]};
    div_ge  = (rem_sh >= {1'b0, den});
    rem_nxt = div_ge ? 32'(rem_sh - {1'b0, den}) : rem_sh[31:0];
    quo_nxt = {num_q[30:0], div_ge};
    raw_bpm = (|quo_nxt[31:16]) ? 16'hFFFF : quo_nxt[15:0];
  end

`ifdef AUTOCORR_TEMPO_MEDIAN3_EN
  logic [15:0]    med_h0 [NCH];
  logic [15:0]    med_h1 [NCH];
  logic [NCH-1:0] med_seeded;

  function automatic logic [15:0] median3(input logic [15:0] a, b, c);
    logic [15:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  // Until a channel has produced its first value the history is meaningless,
  // so the raw value stands in for all three slots.
  assign out_bpm = med_seeded[ch] ? median3(raw_bpm, med_h0[ch], med_h1[ch]) : raw_bpm;

  always_ff @(posedge clk) begin
    if (reset)         med_seeded     <= '0;
    else if (div_done) med_seeded[ch] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (div_done) begin
      med_h0[ch] <= raw_bpm;
      med_h1[ch] <= med_seeded[ch] ? med_h0[ch] : raw_bpm;
    end
  end
`else
  assign out_bpm = raw_bpm;
`endif

  // MAC pipeline: RAM read (1 cycle), registered product, then accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v   <= 1'b0;
      prod_v <= 1'b0;
      prod   <= '0;
    end else begin
      rd_v   <= (state == S_ACC);
      prod_v <= rd_v;
      prod   <= rd_a[ch*W +: CORR_W] * rd_b[ch*W +: CORR_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      fill         <= '0;
      pending      <= 1'b0;
      base         <= '0;
      usable       <= '0;
      ch           <= '0;
      lag          <= '0;
      win_lag      <= '0;
      pairs        <= '0;
      j            <= '0;
      acc          <= '0;
      best_acc     <= '0;
      best_pairs   <= '0;
      best_valid   <= 1'b0;
      drain_cnt    <= 1'b0;
      div_cnt      <= '0;
      num_q        <= '0;
      den          <= '0;
      rem          <= '0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      best_lag     <= '0;
      bpm          <= '0;
      best_score   <= '0;
    end else begin
      result_valid <= 1'b0;

      if (flux_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != FW'(N)) fill <= fill + 1'b1;
      end

      if (prod_v) acc <= acc + ACCW'(prod);

      case (state)
        S_IDLE: begin
          if (pending) begin
            base    <= wr_ptr - 1'b1;
            usable  <= (fill > USABLE_MAX) ? USABLE_MAX : fill;
            pending <= 1'b0;
            ch      <= '0;
            state   <= S_CH_INIT;
          end
        end
        S_CH_INIT: begin
          lag        <= LW'(LAG_MIN);
          best_valid <= 1'b0;
          state      <= S_LAG_INIT;
        end
        S_LAG_INIT: begin
          pairs <= usable - FW'(lag);
          acc   <= '0;
          j     <= '0;
          state <= S_ACC;
        end
        S_ACC: begin
          j <= j + 1'b1;
          if (j == pairs - 1'b1) begin
            drain_cnt <= 1'b0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= S_CMP;
        end
        S_CMP: begin
          if (replace) begin
            best_valid <= 1'b1;
            best_acc   <= acc;
            best_pairs <= pairs;
            win_lag    <= lag;
          end
          if (lag < LW'(LAG_MAX)) begin
            lag   <= lag + 1'b1;
            state <= S_LAG_INIT;
          end else begin
            // Adding lag*128 (half the divisor) rounds the quotient.
            num_q   <= NUM_BASE + (32'(cmp_lag) << 7);
            den     <= 32'(cmp_lag) << 8;
            rem     <= '0;
            div_cnt <= '0;
            state   <= S_DIV;
          end
        end
        S_DIV: begin
          rem     <= rem_nxt;
          num_q   <= quo_nxt;
          div_cnt <= div_cnt + 1'b1;
          if (div_done) begin
            result_valid <= 1'b1;
            result_ch    <= ch;
            best_lag     <= win_lag;
            bpm          <= out_bpm;
            best_score   <= best_acc;
            state        <= S_OUT;
          end
        end
        S_OUT: begin
          if (ch < CHW'(NCH - 1)) begin
            ch    <= ch + 1'b1;
            state <= S_CH_INIT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Placed after the case so a request arriving in IDLE is not lost.
      if (start_ok) pending <= 1'b1;
    end
  end

endmodule
